// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RISC-V control path: FSM states, opcodes,
// ALU operation codes and datapath select values.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_JAL,
      S_BRANCH
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // alu_op tells the ALU decoder whether to force add/sub or decode funct3
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode: forced add/sub or funct3-driven operation.
// Shared between the multicycle FSM and the single-cycle decode path.
module mc_alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op_b5,
   input  logic       funct7b5,
   output logic [2:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         default: begin
            case (funct3)
               // only R-type (op[5]=1) with bit 30 set is a subtract; addi ignores bit 30
               3'b000:  alu_ctrl = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM (Moore): sequences lw/sw/R/I/jal/branch and
// drives datapath selects, write enables and ALU control; branch pc_write follows flags.
module mc_control_unit
   import rv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [3:0] flags,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_write,
   output logic [1:0] imm_src,
   output logic [2:0] alu_ctrl,
   output logic       instr_done,
   output logic       illegal_op
);

   state_t     state_q, state_d, st_eff;
   logic [1:0] alu_op;
   logic       taken;
   logic       flag_n, flag_z, flag_c, flag_v;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BR:        state_d = S_BRANCH;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   assign {flag_n, flag_z, flag_c, flag_v} = flags;

   always_comb begin
      case (funct3)
         3'b000:  taken = flag_z;
         3'b001:  taken = ~flag_z;
         3'b100:  taken = flag_n ^ flag_v;
         3'b101:  taken = ~(flag_n ^ flag_v);
         3'b110:  taken = ~flag_c;
         3'b111:  taken = flag_c;
         default: taken = 1'b0;
      endcase
   end

   // during reset the outputs present FETCH with every enable held low
   assign st_eff = reset ? S_FETCH : state_q;

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      reg_write  = 1'b0;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (st_eff)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_write   = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            if (!(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR})) begin
               illegal_op = 1'b1;
               instr_done = 1'b1;
            end
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNC;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNC;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            pc_write   = taken;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

   always_comb begin
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BR:   imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

   mc_alu_decoder u_alu_dec (
      .alu_op   (alu_op),
      .funct3   (funct3),
      .op_b5    (op[5]),
      .funct7b5 (funct7b5),
      .alu_ctrl (alu_ctrl)
   );

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized instruction streams.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic [3:0] flags;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_ctrl;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic [1:0] imm_src;
      logic [2:0] alu_ctrl;
      logic       instr_done;
      logic       illegal_op;
   } outs_t;

   int total = 0;
   int bad   = 0;
   int m_step = 0;
   bit m_valid = 0;

   always #5 clk = ~clk;

   mc_control_unit dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .flags      (flags),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .result_src (result_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .reg_write  (reg_write),
      .imm_src    (imm_src),
      .alu_ctrl   (alu_ctrl),
      .instr_done (instr_done),
      .illegal_op (illegal_op)
   );

   // cycles an instruction occupies, counted from its fetch
   function automatic int instr_len(input logic [6:0] o);
      case (o)
         7'b0000011: return 5;
         7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
         7'b1100011: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic ob5, input logic f7);
      if (f3 == 3'd0) return (ob5 && f7) ? 3'd1 : 3'd0;
      if (f3 == 3'd2) return 3'd5;
      if (f3 == 3'd6) return 3'd3;
      if (f3 == 3'd7) return 3'd2;
      return 3'd0;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
      logic n, z, c, v;
      n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
      if (f3 == 3'd0) return z;
      if (f3 == 3'd1) return !z;
      if (f3 == 3'd4) return n != v;
      if (f3 == 3'd5) return n == v;
      if (f3 == 3'd6) return !c;
      if (f3 == 3'd7) return c;
      return 1'b0;
   endfunction

   // expected outputs for a given position within the current instruction
   function automatic outs_t model(input int step, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic [3:0] fl, input logic rst);
      outs_t e;
      e = '0;
      e.imm_src = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
                  (o == 7'b1101111) ? 2'd3 : 2'd0;
      if (rst || step == 0) begin
         e.ir_write = !rst; e.pc_write = !rst;
         e.alu_src_b = 2'd2; e.result_src = 2'd2;
      end else if (step == 1) begin
         e.alu_src_a = 2'd1; e.alu_src_b = 2'd1;
         if (instr_len(o) == 2) begin e.illegal_op = 1; e.instr_done = 1; end
      end else begin
         case (o)
            7'b0000011: begin
               if (step == 2) begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
               else if (step == 3) e.adr_src = 1;
               else begin e.result_src = 2'd1; e.reg_write = 1; e.instr_done = 1; end
            end
            7'b0100011: begin
               if (step == 2) begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
               else begin e.adr_src = 1; e.mem_write = 1; e.instr_done = 1; end
            end
            7'b0110011, 7'b0010011: begin
               if (step == 2) begin
                  e.alu_src_a = 2'd2;
                  e.alu_src_b = (o == 7'b0110011) ? 2'd0 : 2'd1;
                  e.alu_ctrl  = alu_fn(f3, o[5], f7);
               end else begin e.reg_write = 1; e.instr_done = 1; end
            end
            7'b1101111: begin
               if (step == 2) begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.pc_write = 1; end
               else begin e.reg_write = 1; e.instr_done = 1; end
            end
            default: begin
               e.alu_src_a = 2'd2; e.alu_ctrl = 3'd1;
               e.pc_write = br_taken(f3, fl); e.instr_done = 1;
            end
         endcase
      end
      return e;
   endfunction

   task automatic model_check();
      outs_t e, a;
      a = '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
            reg_write, imm_src, alu_ctrl, instr_done, illegal_op};
      if (reset || m_valid) begin
         e = model(m_step, op, funct3, funct7b5, flags, reset);
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL model t=%0t step=%0d op=%b f3=%0d: got %05h want %05h",
                     $time, m_step, op, funct3, a, e);
         end
      end
      if (reset) begin
         m_valid = 1;
         m_step  = 0;
      end else if (m_valid) begin
         m_step = (m_step + 1 >= instr_len(op)) ? 0 : m_step + 1;
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [6:0] o, input logic [2:0] f, input logic f7,
                      input logic [3:0] fl, input logic r);
      @(negedge clk);
      op = o; funct3 = f; funct7b5 = f7; flags = fl; reset = r;
      #2;
      model_check();
   endtask

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

   initial begin
      logic [6:0] rop;
      logic [2:0] rf3;
      logic       rf7;
      reset = 1; op = LW; funct3 = 0; funct7b5 = 0; flags = 0;

      cyc(LW, 0, 0, 0, 1);
      chk("rst_pc_write", {7'd0, pc_write}, 0);
      chk("rst_ir_write", {7'd0, ir_write}, 0);
      chk("rst_alu_src_b", {6'd0, alu_src_b}, 2);
      chk("rst_result_src", {6'd0, result_src}, 2);
      cyc(LW, 0, 0, 0, 1);

      // lw: five cycles, write-back only in the last
      cyc(LW, 2, 0, 0, 0); chk("lw_fetch_ir", {7'd0, ir_write}, 1);
      cyc(LW, 2, 0, 0, 0); chk("lw_dec_srca", {6'd0, alu_src_a}, 1);
      cyc(LW, 2, 0, 0, 0); chk("lw_memadr_srca", {6'd0, alu_src_a}, 2);
      cyc(LW, 2, 0, 0, 0); chk("lw_memread_adr", {7'd0, adr_src}, 1);
      chk("lw_memread_rw", {7'd0, reg_write}, 0);
      cyc(LW, 2, 0, 0, 0); chk("lw_wb_rw", {7'd0, reg_write}, 1);
      chk("lw_wb_res", {6'd0, result_src}, 1);
      chk("lw_wb_done", {7'd0, instr_done}, 1);

      // sub R-type
      cyc(RT, 0, 1, 0, 0); cyc(RT, 0, 1, 0, 0);
      cyc(RT, 0, 1, 0, 0); chk("sub_alu_ctrl", {5'd0, alu_ctrl}, 1);
      cyc(RT, 0, 1, 0, 0); chk("sub_aluwb_rw", {7'd0, reg_write}, 1);
      cyc(IT, 0, 1, 0, 0); cyc(IT, 0, 1, 0, 0);
      cyc(IT, 0, 1, 0, 0); chk("addi_alu_ctrl", {5'd0, alu_ctrl}, 0);
      cyc(IT, 0, 1, 0, 0);

      // branches
      cyc(BR, 0, 0, 4'b0100, 0); cyc(BR, 0, 0, 4'b0100, 0);
      cyc(BR, 0, 0, 4'b0100, 0); chk("beq_taken", {7'd0, pc_write}, 1);
      cyc(BR, 0, 0, 4'b0000, 0); cyc(BR, 0, 0, 4'b0000, 0);
      cyc(BR, 0, 0, 4'b0000, 0); chk("beq_not_taken", {7'd0, pc_write}, 0);
      cyc(BR, 6, 0, 4'b0000, 0); cyc(BR, 6, 0, 4'b0000, 0);
      cyc(BR, 6, 0, 4'b0000, 0); chk("bltu_taken", {7'd0, pc_write}, 1);
      flags = 4'b0010; #1; chk("bltu_not_taken", {7'd0, pc_write}, 0);
      cyc(BR, 5, 0, 4'b1001, 0); cyc(BR, 5, 0, 4'b1001, 0);
      cyc(BR, 5, 0, 4'b1001, 0); chk("bge_taken", {7'd0, pc_write}, 1);

      // jal
      cyc(JL, 0, 0, 0, 0); cyc(JL, 0, 0, 0, 0);
      cyc(JL, 0, 0, 0, 0); chk("jal_pc_write", {7'd0, pc_write}, 1);
      chk("jal_imm_src", {6'd0, imm_src}, 3);
      cyc(JL, 0, 0, 0, 0); chk("jal_aluwb_rw", {7'd0, reg_write}, 1);

      // unsupported opcode
      cyc(7'b0110111, 0, 0, 0, 0);
      cyc(7'b0110111, 0, 0, 0, 0); chk("ill_illegal", {7'd0, illegal_op}, 1);
      chk("ill_done", {7'd0, instr_done}, 1);
      chk("ill_writes", {4'd0, pc_write, ir_write, reg_write, mem_write}, 0);

      // sw aborted by reset in MEMWRITE
      cyc(SW, 2, 0, 0, 0); chk("sw_fetch_after_ill", {7'd0, ir_write}, 1);
      cyc(SW, 2, 0, 0, 0); cyc(SW, 2, 0, 0, 0);
      cyc(SW, 2, 0, 0, 1); chk("sw_rst_mem_write", {7'd0, mem_write}, 0);
      cyc(SW, 2, 0, 0, 0); chk("sw_rst_to_fetch", {6'd0, pc_write, ir_write}, 3);

      // randomized instruction stream
      rop = SW; rf3 = 2; rf7 = 0;
      for (int i = 0; i < 3000; i++) begin
         if (m_step == 0) begin
            case ($urandom_range(0, 7))
               0: rop = LW;
               1: rop = SW;
               2: rop = RT;
               3: rop = IT;
               4: rop = JL;
               5: rop = BR;
               6: rop = 7'($urandom);
               default: rop = 7'b0110111;
            endcase
            rf3 = 3'($urandom);
            rf7 = 1'($urandom);
         end
         cyc(rop, rf3, rf7, 4'($urandom), $urandom_range(0, 49) == 0);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
